vga_out_dither: RTL

Output stage between the test-pattern controller's RGB888 and the DAC buffers. It applies 4x4 ordered (Bayer) dithering, optionally rotated per frame, and reduces each channel to `OUT_BITS` for the DACs. It delays hsync, vsync, hblank and vblank by the same two-stage pipeline so sync and blanking stay pixel-aligned with colour. Blanked pixels are forced to zero at the output.

---
 rtl/vga_out_pkg.sv | 14 +
 rtl/vga_out_dither_channel.sv | 18 +
 rtl/vga_out_dither.sv | 111 +++++++++++
 3 files changed

// File: rtl/vga_out_pkg.sv
// vga_out_pkg: Bayer matrix and OUT_BITS limits shared by the VGA output dither stage
package vga_out_pkg;
  localparam int OUT_BITS_MIN = 4;
  localparam int OUT_BITS_MAX = 7;
  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };
  function automatic logic [3:0] bayer_at(input logic [1:0] y, input logic [1:0] x);
    return BAYER[y][x];
  endfunction
endpackage

// File: rtl/vga_out_dither_channel.sv
// dither_channel: registered threshold add, saturate, reduce to OUT_BITS and blank-to-zero for one colour
module dither_channel #(
  parameter int OUT_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            pix,
  input  logic [7-OUT_BITS:0]   thr,
  input  logic                  blank,
  output logic [OUT_BITS-1:0]   dout
);
  localparam int S = 8 - OUT_BITS;
  logic [8:0] sum;
  assign sum = {1'b0, pix} + {{(9 - S){1'b0}}, thr};
  // a carry out of bit 7 saturates to full scale instead of wrapping to black
  always_ff @(posedge clk)
    dout <= (reset || blank) ? '0 : sum[8] ? '1 : sum[7:S];
endmodule

// File: rtl/vga_out_dither.sv
// vga_out_dither: 4x4 Bayer dither of RGB888 to OUT_BITS DAC codes with 2-clock aligned sync/blank; VGA_DITHER_TEMPORAL_EN adds per-frame matrix rotation
module vga_out_dither
  import vga_out_pkg::*;
#(
  parameter int OUT_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_r,
  input  logic [7:0]          in_g,
  input  logic [7:0]          in_b,
  input  logic                in_hsync,
  input  logic                in_vsync,
  input  logic                in_hblank,
  input  logic                in_vblank,
  input  logic                dither_en,
  output logic [OUT_BITS-1:0] out_r,
  output logic [OUT_BITS-1:0] out_g,
  output logic [OUT_BITS-1:0] out_b,
  output logic                out_hsync,
  output logic                out_vsync,
  output logic                out_hblank,
  output logic                out_vblank
);
  localparam int S = 8 - OUT_BITS;
  localparam int SH = OUT_BITS - 4;
  if (OUT_BITS < OUT_BITS_MIN || OUT_BITS > OUT_BITS_MAX) begin : g_bad_out_bits
    $error("vga_out_dither: OUT_BITS must lie in 4..7");
  end
  logic [1:0] x_ph, y_ph, xi, yi;
  logic prev_hblank;
  logic [3:0] bay;
  logic [S-1:0] thr, thr_q;
  logic [7:0] r_q, g_q, b_q;
  logic hs_q, vs_q, hb_q, vb_q;
`ifdef VGA_DITHER_TEMPORAL_EN
  logic [1:0] frame;
  logic prev_vblank;
  // frame count advances on each vblank rising edge to rotate the matrix
  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
      prev_vblank <= 1'b1;
    end else begin
      frame <= (in_vblank && !prev_vblank) ? frame + 2'd1 : frame;
      prev_vblank <= in_vblank;
    end
  end
  assign xi = x_ph + frame;
  assign yi = y_ph + {frame[0], frame[1]};
`else
  assign xi = x_ph;
  assign yi = y_ph;
`endif
  // screen-position phase counters; blanking clears, hblank rise advances the line phase
  always_ff @(posedge clk) begin
    if (reset) begin
      x_ph <= '0;
      y_ph <= '0;
      prev_hblank <= 1'b1;
    end else begin
      x_ph <= in_hblank ? 2'd0 : x_ph + 2'd1;
      y_ph <= in_vblank ? 2'd0 : (in_hblank && !prev_hblank) ? y_ph + 2'd1 : y_ph;
      prev_hblank <= in_hblank;
    end
  end
  // threshold from the current pixel's phase, scaled to the bits being dropped
  always_comb begin
    bay = bayer_at(yi, xi);
    thr = dither_en ? S'(bay >> SH) : '0;
  end
  // stage 1: capture colour, threshold, sync and blank
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      thr_q <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      hb_q <= 1'b1;
      vb_q <= 1'b1;
    end else begin
      r_q <= in_r;
      g_q <= in_g;
      b_q <= in_b;
      thr_q <= thr;
      hs_q <= in_hsync;
      vs_q <= in_vsync;
      hb_q <= in_hblank;
      vb_q <= in_vblank;
    end
  end
  // stage 2: sync and blank leave alongside the channel results
  always_ff @(posedge clk) begin
    if (reset) begin
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_hblank <= 1'b1;
      out_vblank <= 1'b1;
    end else begin
      out_hsync <= hs_q;
      out_vsync <= vs_q;
      out_hblank <= hb_q;
      out_vblank <= vb_q;
    end
  end
  dither_channel #(.OUT_BITS(OUT_BITS)) u_r (.clk(clk), .reset(reset), .pix(r_q), .thr(thr_q), .blank(hb_q | vb_q), .dout(out_r));
  dither_channel #(.OUT_BITS(OUT_BITS)) u_g (.clk(clk), .reset(reset), .pix(g_q), .thr(thr_q), .blank(hb_q | vb_q), .dout(out_g));
  dither_channel #(.OUT_BITS(OUT_BITS)) u_b (.clk(clk), .reset(reset), .pix(b_q), .thr(thr_q), .blank(hb_q | vb_q), .dout(out_b));
endmodule
